// File: rtl/serial_frame_pkg.sv
// -----------------------------------------------------------------------------
// serial_frame_pkg
//   Shared definitions for the serial frame receiver:
//     - default field widths (command, data, bit counter)
//     - frame width derivation (adds one parity bit when FRAME_PARITY_EN is set)
//     - receiver FSM state encoding (IDLE, SHIFT, WAIT_END)
//   Optional feature macro: FRAME_PARITY_EN
// -----------------------------------------------------------------------------
package serial_frame_pkg;

  localparam int CMD_W_DEF  = 8;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 6;

`ifdef FRAME_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Total number of serial bits that make up one frame.
  function automatic int frame_w(input int cmd_w, input int data_w);
    return cmd_w + data_w + PAR_W;
  endfunction

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } state_e;

endpackage

// File: rtl/rx_bit_counter.sv
// -----------------------------------------------------------------------------
// rx_bit_counter
//   Counts accepted serial bits 0..FRAME_W-1 and flags when the next accepted
//   bit is the final bit of the frame.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (count -> 0)
//   inc      in  an accepted bit is being shifted in this cycle
//   clr      in  synchronous clear (frame complete or aborted); wins over inc
//   last     out count == FRAME_W-1 (the bit being accepted completes the frame)
// -----------------------------------------------------------------------------
module rx_bit_counter #(
  parameter int CNT_W   = 6,
  parameter int FRAME_W = 40
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(FRAME_W - 1));

endmodule

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//   Serial-to-parallel front end for command/data frames. Bits arrive MSB
//   first (command then data, plus an even-parity bit when FRAME_PARITY_EN is
//   defined) and are accepted on cycles where frame_active & sin_valid. Each
//   complete frame is offered on a single-entry valid/ready output register.
//   Optional feature macro: FRAME_PARITY_EN
//
// Handshake: out_valid/out_cmd/out_data/out_perr form one valid/ready channel.
//   A frame transfers on any cycle with out_valid & out_ready. While out_valid
//   is high and out_ready low the payload is held stable. A frame completing
//   into a full, stalled register is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   frame_active           frame in progress (chip select)
//   sin, sin_valid         serial bit and its strobe
//   out_valid, out_ready   output handshake
//   out_cmd, out_data      received command / data fields
//   out_perr               parity error for held frame (0 without parity)
//   frame_abort            one-cycle pulse: frame_active fell mid-frame
//   overflow, ovf_clr      sticky dropped-frame flag and its clear
//   dbg_state              current FSM state
// -----------------------------------------------------------------------------
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int CMD_W  = CMD_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_active,
  input  logic              sin,
  input  logic              sin_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CMD_W-1:0]  out_cmd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              frame_abort,
  output logic              overflow,
  input  logic              ovf_clr,
  output state_e            dbg_state
);

  localparam int FRAME_W = frame_w(CMD_W, DATA_W);

  state_e             state;
  logic [FRAME_W-2:0] shift_q;
  logic [FRAME_W-1:0] frame_next;
  logic [CMD_W-1:0]   cmd_next;
  logic [DATA_W-1:0]  data_next;
  logic               perr_next;
  logic               accept;
  logic               complete;
  logic               abort;
  logic               cnt_last;

  assign accept   = frame_active & sin_valid;
  assign complete = (state == SHIFT) & accept & cnt_last;
  assign abort    = (state == SHIFT) & ~frame_active;

  // Full frame as it stands once the current bit is shifted in.
  assign frame_next = {shift_q, sin};
  assign cmd_next   = frame_next[FRAME_W-1 -: CMD_W];
  assign data_next  = frame_next[FRAME_W-CMD_W-1 -: DATA_W];

`ifdef FRAME_PARITY_EN
  // Even parity: XOR of all bits including the parity bit must be 0.
  assign perr_next = ^frame_next;
`else
  assign perr_next = 1'b0;
`endif

  rx_bit_counter #(
    .CNT_W   (CNT_W),
    .FRAME_W (FRAME_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (accept & (state != WAIT_END)),
    .clr     (complete | abort),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shift_q     <= '0;
      out_valid   <= 1'b0;
      out_cmd     <= '0;
      out_data    <= '0;
      out_perr    <= 1'b0;
      frame_abort <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_abort <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            shift_q <= frame_next[FRAME_W-2:0];
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!frame_active) begin
            frame_abort <= 1'b1;
            shift_q     <= '0;
            state       <= IDLE;
          end else if (accept) begin
            if (cnt_last) begin
              shift_q <= '0;
              state   <= WAIT_END;
            end else begin
              shift_q <= frame_next[FRAME_W-2:0];
            end
          end
        end
        WAIT_END: begin
          // Extra strobes after a full frame are ignored until deselect.
          if (!frame_active) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Holding register: load when empty or being drained this cycle.
      if (complete && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_cmd   <= cmd_next;
        out_data  <= data_next;
        out_perr  <= perr_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Set has priority over a simultaneous clear.
      if (complete && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule
